// File: rtl/speed_sel_pkg.sv
// Shared constants and debounce FSM encoding for the speed selector.
package speed_sel_pkg;

  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned CNT_W   = 24;

  localparam logic [LEVEL_W-1:0] LEVEL_MIN = 2'd0;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } db_state_e;

endpackage

// File: rtl/speed_selector_if.sv
// Button inputs and level/debounce outputs of the speed selector.
interface speed_selector_if;
  import speed_sel_pkg::*;

  logic               btn_up;
  logic               btn_down;
  logic [LEVEL_W-1:0] level;
  logic               level_changed;
  logic               up_db;
  logic               down_db;

  modport master (
    output btn_up,
    output btn_down,
    input  level,
    input  level_changed,
    input  up_db,
    input  down_db
  );

  modport slave (
    input  btn_up,
    input  btn_down,
    output level,
    output level_changed,
    output up_db,
    output down_db
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce FSM; emits a one-cycle press pulse and
// the debounced button state.
module btn_debounce
  import speed_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o,
  output logic db_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             db_q;
  logic             btn_s;

  assign btn_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= StIdle;
      cnt_q   <= '0;
      press_q <= 1'b0;
      db_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (btn_s) begin
            state_q <= StPressWait;
            cnt_q   <= '0;
          end
        end
        StPressWait: begin
          if (!btn_s) begin
            state_q <= StIdle;
          end else if (cnt_q == CntLast) begin
            // Counter stops here; the next entry into a wait state clears it.
            state_q <= StPressed;
            press_q <= 1'b1;
            db_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPressed: begin
          if (!btn_s) begin
            state_q <= StReleaseWait;
            cnt_q   <= '0;
          end
        end
        StReleaseWait: begin
          if (btn_s) begin
            state_q <= StPressed;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdle;
            db_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign press_o = press_q;
  assign db_o    = db_q;

endmodule

// File: rtl/speed_selector.sv
// Two debounced buttons step a 2-bit speed level. Define SPEED_SEL_WRAP_EN to
// wrap 3->0 / 0->3 instead of saturating.
module speed_selector
  import speed_sel_pkg::*;
#(
  parameter int unsigned        DEBOUNCE_CYCLES = 1000000,
  parameter logic [LEVEL_W-1:0] RESET_LEVEL     = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  speed_selector_if.slave  bus
);

  logic               up_press;
  logic               down_press;
  logic               up_db;
  logic               down_db;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic               changed_q;
  logic               changed_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_up (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (bus.btn_up),
    .press_o(up_press),
    .db_o   (up_db)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_down (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (bus.btn_down),
    .press_o(down_press),
    .db_o   (down_db)
  );

  // Simultaneous up and down presses cancel out.
  always_comb begin
    level_d = level_q;
    if (up_press && !down_press) begin
`ifdef SPEED_SEL_WRAP_EN
      level_d = level_q + LEVEL_W'(1);
`else
      if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_W'(1);
`endif
    end else if (down_press && !up_press) begin
`ifdef SPEED_SEL_WRAP_EN
      level_d = level_q - LEVEL_W'(1);
`else
      if (level_q != LEVEL_MIN) level_d = level_q - LEVEL_W'(1);
`endif
    end
  end

  assign changed_d = (level_d != level_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= RESET_LEVEL;
      changed_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      changed_q <= changed_d;
    end
  end

  assign bus.level         = level_q;
  assign bus.level_changed = changed_q;
  assign bus.up_db         = up_db;
  assign bus.down_db       = down_db;

endmodule

// File: tb/tb_speed_selector.sv
// Directed bench for speed_selector with a run-length reference model checked
// every cycle, plus hand-computed literal checkpoints.
module tb_speed_selector;
  import speed_sel_pkg::*;

  localparam int unsigned N = 4;
`ifdef SPEED_SEL_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  speed_selector_if bus ();

  speed_selector #(
    .DEBOUNCE_CYCLES(N),
    .RESET_LEVEL    (2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a button's debounced state flips once the synchronized
  // input has held the opposite value for N+1 consecutive samples.
  int m_lvl;
  bit m_chg;
  bit m_db[2];
  bit m_ev[2];
  bit m_p0[2];
  bit m_p1[2];
  bit m_rv[2];
  int m_run[2];
  bit started = 1'b0;

  always @(posedge clk) begin
    bit raw[2];
    bit s;
    int old;
    raw[0] = bus.btn_up;
    raw[1] = bus.btn_down;
    if (rst) begin
      m_lvl = 1;
      m_chg = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_db[b] = 1'b0; m_ev[b] = 1'b0; m_p0[b] = 1'b0; m_p1[b] = 1'b0;
        m_rv[b] = 1'b0; m_run[b] = 0;
      end
      started = 1'b1;
    end else begin
      old = m_lvl;
      if (m_ev[0] && !m_ev[1])
        m_lvl = Wrap ? (m_lvl + 1) % 4 : (m_lvl < 3 ? m_lvl + 1 : 3);
      else if (m_ev[1] && !m_ev[0])
        m_lvl = Wrap ? (m_lvl + 3) % 4 : (m_lvl > 0 ? m_lvl - 1 : 0);
      m_chg = (m_lvl != old);
      for (int b = 0; b < 2; b++) begin
        s = m_p1[b];
        m_p1[b] = m_p0[b];
        m_p0[b] = raw[b];
        if (s == m_rv[b]) m_run[b]++;
        else begin
          m_rv[b]  = s;
          m_run[b] = 1;
        end
        m_ev[b] = 1'b0;
        if (m_run[b] == int'(N) + 1 && m_db[b] != s) begin
          m_db[b] = s;
          m_ev[b] = s;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (bus.level !== 2'(m_lvl) || bus.level_changed !== m_chg ||
          bus.up_db !== m_db[0] || bus.down_db !== m_db[1]) begin
        miscompares++;
        $display("FAIL cycle t=%0t level=%0d want %0d changed=%0b want %0b up_db=%0b want %0b down_db=%0b want %0b",
                 $time, bus.level, m_lvl, bus.level_changed, m_chg, bus.up_db, m_db[0],
                 bus.down_db, m_db[1]);
      end
    end
  end

  int pulse_cnt   = 0;
  int m_pulse_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (bus.level_changed === 1'b1) pulse_cnt++;
    if (m_chg) m_pulse_cnt++;
  end

  task automatic chk(input string name, input int act, input int mdl, input int exp);
    vectors++;
    if (act != exp || mdl != exp) begin
      miscompares++;
      $display("FAIL %s: dut=%0d model=%0d expected=%0d", name, act, mdl, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic clr_pulses();
    pulse_cnt   = 0;
    m_pulse_cnt = 0;
  endtask

  task automatic press(input bit up, input bit dn);
    bus.btn_up   = up;
    bus.btn_down = dn;
    step(10);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(10);
  endtask

  initial begin
    int lvl_before;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    step(2);
    rst = 1'b0;

    chk("reset level", bus.level, m_lvl, 1);
    chk("reset changed", bus.level_changed, m_chg, 0);
    chk("reset up_db", bus.up_db, m_db[0], 0);
    chk("reset down_db", bus.down_db, m_db[1], 0);

    // Up held from edge 0: level steps at edge 7.
    bus.btn_up = 1'b1;
    step(7);
    chk("up edge6 level", bus.level, m_lvl, 1);
    chk("up edge6 changed", bus.level_changed, m_chg, 0);
    step(1);
    chk("up edge7 level", bus.level, m_lvl, 2);
    chk("up edge7 changed", bus.level_changed, m_chg, 1);
    chk("up edge7 up_db", bus.up_db, m_db[0], 1);
    step(1);
    chk("up edge8 changed", bus.level_changed, m_chg, 0);
    bus.btn_up = 1'b0;
    step(10);
    chk("up released db", bus.up_db, m_db[0], 0);

    // Bouncy down button then a steady hold.
    clr_pulses();
    repeat (5) begin
      bus.btn_down = 1'b1;
      step(3);
      bus.btn_down = 1'b0;
      step(1);
    end
    chk("bounce level", bus.level, m_lvl, 2);
    chk("bounce pulses", pulse_cnt, m_pulse_cnt, 0);
    bus.btn_down = 1'b1;
    step(10);
    chk("bounce hold level", bus.level, m_lvl, 1);
    chk("bounce hold pulses", pulse_cnt, m_pulse_cnt, 1);
    chk("bounce hold down_db", bus.down_db, m_db[1], 1);
    bus.btn_down = 1'b0;
    step(10);

    // From 0, three clean up presses.
    press(1'b0, 1'b1);
    chk("to zero level", bus.level, m_lvl, 0);
    clr_pulses();
    press(1'b1, 1'b0);
    chk("climb 1", bus.level, m_lvl, 1);
    press(1'b1, 1'b0);
    chk("climb 2", bus.level, m_lvl, 2);
    press(1'b1, 1'b0);
    chk("climb 3", bus.level, m_lvl, 3);
    chk("climb pulses", pulse_cnt, m_pulse_cnt, 3);

    // Up press at the top level.
    clr_pulses();
    press(1'b1, 1'b0);
    chk("top up level", bus.level, m_lvl, Wrap ? 0 : 3);
    chk("top up pulses", pulse_cnt, m_pulse_cnt, Wrap ? 1 : 0);

    // Both buttons on the same edge cancel.
    lvl_before = Wrap ? 0 : 3;
    clr_pulses();
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    step(8);
    chk("both up_db", bus.up_db, m_db[0], 1);
    chk("both down_db", bus.down_db, m_db[1], 1);
    chk("both level", bus.level, m_lvl, lvl_before);
    step(4);
    chk("both pulses", pulse_cnt, m_pulse_cnt, 0);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step(10);

    // Reset at edge 5 of a held up press; re-debounced from scratch.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    bus.btn_up = 1'b1;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst level", bus.level, m_lvl, 1);
    chk("midrst up_db", bus.up_db, m_db[0], 0);
    clr_pulses();
    step(7);
    chk("midrst pre level", bus.level, m_lvl, 1);
    step(1);
    chk("midrst step level", bus.level, m_lvl, 2);
    chk("midrst step changed", bus.level_changed, m_chg, 1);
    step(5);
    chk("midrst pulses", pulse_cnt, m_pulse_cnt, 1);
    bus.btn_up = 1'b0;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/speed_selector.md
SPEED_SELECTOR -- requirements
Module: speed_selector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, count of consecutive stable synchronized samples needed to accept a transition (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter RESET_LEVEL, default 2'b01, value loaded into level on reset (1 s breathing cycle).
REQ-003 clk  input  1  single system clock, 50 MHz; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 btn_up  input  1  raw asynchronous push-button, high = pressed, bouncy.
REQ-006 btn_down  input  1  raw asynchronous push-button, high = pressed, bouncy.
REQ-007 level  output  2  registered speed level, driven directly to breathing_light light_lever.
REQ-008 level_changed  output  1  registered one-cycle pulse, high on the cycle level takes a new value.
REQ-009 up_db, down_db  output  1 each  registered debounced button states.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Each button SHALL have a debounce FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE -> PRESS_WAIT when synchronized input is high; counter cleared.
REQ-013 PRESS_WAIT: counter increments each cycle input is high; input low -> IDLE, no event; count reaching DEBOUNCE_CYCLES -> PRESSED, press event pulsed for one cycle, db output set high.
REQ-014 PRESSED -> RELEASE_WAIT when input low; RELEASE_WAIT returns to PRESSED on input high (no event) or to IDLE after DEBOUNCE_CYCLES consecutive low samples, db output cleared.
REQ-015 Holding a button SHALL produce exactly one press event (no auto-repeat).
REQ-016 Latency: raw input held high from edge k SHALL update level at edge k+DEBOUNCE_CYCLES+3 (2 sync + N debounce + 1 level register).
REQ-017 Up event alone: level+1; down event alone: level-1; saturating at 3 and 0 by default.
REQ-018 Up and down events in the same cycle SHALL leave level unchanged, no pulse.
REQ-019 level_changed SHALL assert only when level's value actually changes; a saturated step produces no pulse.
REQ-020 Counter width SHALL be 24 bits; counter never wraps (stops at terminal count).

Reset
REQ-021 On rst: level=RESET_LEVEL, level_changed=0, up_db=down_db=0, synchronizers=0, FSMs=IDLE, counters=0.
REQ-022 Reset mid-debounce SHALL discard the pending transition; a button held through reset release SHALL be re-debounced from IDLE and generate one press event.

Configuration
REQ-023 Macro SPEED_SEL_WRAP_EN defined: level wraps 3->0 on up and 0->3 on down, level_changed pulses on each wrap step.
REQ-024 Macro SPEED_SEL_WRAP_EN undefined: saturating behaviour per REQ-017/REQ-019.

Structure
REQ-025 Package speed_sel_pkg SHALL hold the debounce FSM state encoding, LEVEL_W=2, CNT_W=24, LEVEL_MIN=0, LEVEL_MAX=3.
REQ-026 Sub-module btn_debounce (synchronizer + FSM + counter, outputs press pulse and db state) SHALL be instantiated twice; level arithmetic stays in speed_selector.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-027 Reset, btn_up held high from edge 0 -> level 01->10 at edge 7, level_changed high for edge 7 only, up_db high.
REQ-028 btn_down bouncing high 3 cycles, low 1, repeat 5 times, then held 10 cycles -> exactly one decrement, no event during bounce.
REQ-029 Level=11, one clean up press -> level stays 11, level_changed never asserts; repeat with SPEED_SEL_WRAP_EN -> level 00, one pulse.
REQ-030 Both buttons pressed on the same edge and held -> level unchanged, no pulse, up_db and down_db both high at edge 7.
REQ-031 rst asserted for one cycle at edge 5 of a held up press -> level=01 after reset, single increment to 10 exactly 7 edges after rst deasserts.
REQ-032 Level=00, three clean up presses separated by full releases -> level 01, 10, 11 with three single-cycle pulses.
